// File: rtl/mem_responder.sv
// Word-addressed RAM behind valid/ready request and response channels, answering each
// request a fixed LATENCY cycles after it is accepted.
module mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];

  logic          enter_resp;
  logic          acc_wen, acc_err;
  logic [31:0]   acc_addr, acc_wdata, acc_off;
  logic [3:0]    acc_wmask;
  logic [AW-1:0] acc_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // With LATENCY==1 the access happens on the accepting edge, so the live request is used.
  always_comb begin
    if (state_q == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
    acc_off = acc_addr - BASE;
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_off >= SPAN);
    acc_idx = acc_off[AW+1:2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_wen || acc_err) ? 32'h0 : mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && acc_wen && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 3, 4) checked every cycle against a
// transaction-level model, plus directed transactions with literal expectations.
module tb_mem_responder;

  logic        clk, rst;
  logic        req_valid [3], req_ready [3], req_wen [3];
  logic        rsp_valid [3], rsp_ready [3], rsp_err [3];
  logic [31:0] req_addr [3], req_wdata [3], rsp_rdata [3];
  logic [3:0]  req_wmask [3];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wen(req_wen[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, response appears LATENCY cycles after accept.
  logic [31:0] mm [3][1024];
  bit          m_busy [3], m_valid [3];
  int          m_cnt [3];
  logic        m_wen [3], m_err [3];
  logic [31:0] m_addr [3], m_wdata [3], m_rdata [3];
  logic [3:0]  m_mask [3];

  task automatic do_access(input int i);
    logic [31:0] off;
    logic        e;
    int          idx;
    off = m_addr[i] - 32'h8000_0000;
    e = (m_addr[i] % 4 != 0) || (off >= 32'd4096);
    m_err[i]   = e;
    m_rdata[i] = 32'h0;
    if (!e) begin
      idx = int'(off / 4);
      if (m_wen[i]) begin
        for (int b = 0; b < 4; b++)
          if (m_mask[i][b]) mm[i][idx][8*b +: 8] = m_wdata[i][8*b +: 8];
      end else begin
        m_rdata[i] = mm[i][idx];
      end
    end
    m_valid[i] = 1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_valid[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_rdata[i] = 0;
      for (int k = 0; k < 1024; k++) mm[i][k] = 32'h0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 0; m_valid[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_rdata[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_valid[i]) begin
          if (rsp_ready[i]) begin
            m_valid[i] = 0;
            m_busy[i]  = 0;
          end
        end else if (m_busy[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == lat_of(i)) do_access(i);
        end else if (req_valid[i]) begin
          m_wen[i] = req_wen[i]; m_addr[i] = req_addr[i];
          m_wdata[i] = req_wdata[i]; m_mask[i] = req_wmask[i];
          m_busy[i] = 1;
          m_cnt[i]  = 1;
          if (lat_of(i) == 1) do_access(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("req_ready", i, 32'(req_ready[i]), 32'(!m_busy[i]));
        check("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_valid[i]));
        if (m_valid[i]) begin
          check("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
          check("rsp_err", i, 32'(rsp_err[i]), 32'(m_err[i]));
        end
      end
    end
  end

  task automatic xact(input int i, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk); #1;
    req_valid[i] = 1; req_wen[i] = wen; req_addr[i] = addr; req_wdata[i] = wdata; req_wmask[i] = mask;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept_in_time", i, 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 0;
    lat = 1;
    n = 0;
    while (!rsp_valid[i] && n < 50) begin
      @(posedge clk); #1;
      lat++;
      n++;
    end
    check("rsp_in_time", i, 32'(n < 50), 32'd1);
    rdata = rsp_rdata[i];
    err   = rsp_err[i];
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", i, 32'(rsp_valid[i]), 32'd1);
      check("hold_rsp_rdata", i, rsp_rdata[i], rdata);
      check("hold_req_ready", i, 32'(req_ready[i]), 32'd0);
    end
    rsp_ready[i] = 1;
    @(posedge clk); #1;
    rsp_ready[i] = 0;
    check("req_ready_after_hs", i, 32'(req_ready[i]), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 0; req_wen[i] = 0; req_addr[i] = 0; req_wdata[i] = 0;
      req_wmask[i] = 0; rsp_ready[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1;
    #1 rst = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_req_ready", i, 32'(req_ready[i]), 32'd1);
      check("reset_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      check("reset_rsp_rdata", i, rsp_rdata[i], 32'h0);
      check("reset_rsp_err", i, 32'(rsp_err[i]), 32'd0);
    end

    // LATENCY=1 basic write/read and byte masks
    xact(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lt);
    check("l1_wr_lat", 0, lt, 1); check("l1_wr_err", 0, 32'(er), 0); check("l1_wr_rdata", 0, rd, 32'h0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lt);
    check("l1_rd_lat", 0, lt, 1); check("l1_rd_data", 0, rd, 32'hDEAD_BEEF);
    xact(0, 1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, rd, er, lt);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lt);
    check("mask_rd_data", 0, rd, 32'hDE22_BE44);
    xact(0, 1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lt);
    check("mask0_err", 0, 32'(er), 0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lt);
    check("mask0_rd_data", 0, rd, 32'hDE22_BE44);

    // rsp_ready high while idle must be harmless
    @(negedge clk); #1 rsp_ready[0] = 1;
    repeat (3) @(negedge clk);
    #1 rsp_ready[0] = 0;

    // Error cases and range boundary
    xact(0, 0, 32'h8000_0002, 32'h0, 4'h0, 0, rd, er, lt);
    check("misalign_err", 0, 32'(er), 1); check("misalign_rdata", 0, rd, 32'h0); check("misalign_lat", 0, lt, 1);
    xact(0, 1, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, rd, er, lt);
    xact(0, 1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lt);
    check("below_base_err", 0, 32'(er), 1);
    xact(0, 1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lt);
    check("above_top_err", 0, 32'(er), 1);
    xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lt);
    check("word0_unchanged", 0, rd, 32'h1234_5678); check("word0_err", 0, 32'(er), 0);
    xact(0, 1, 32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF, 0, rd, er, lt);
    xact(0, 0, 32'h8000_0FFC, 32'h0, 4'h0, 0, rd, er, lt);
    check("last_word_rd", 0, rd, 32'hA5A5_5A5A); check("last_word_err", 0, 32'(er), 0);

    // LATENCY=3 with response backpressure
    xact(1, 1, 32'h8000_0040, 32'h0BAD_CAFE, 4'hF, 0, rd, er, lt);
    check("l3_wr_lat", 1, lt, 3);
    xact(1, 0, 32'h8000_0040, 32'h0, 4'h0, 4, rd, er, lt);
    check("l3_rd_lat", 1, lt, 3); check("l3_rd_data", 1, rd, 32'h0BAD_CAFE);

    // LATENCY=4, reset during WAIT abandons the write
    xact(2, 1, 32'h8000_0020, 32'h1111_1111, 4'hF, 0, rd, er, lt);
    check("l4_wr_lat", 2, lt, 4);
    @(negedge clk); #1;
    req_valid[2] = 1; req_wen[2] = 1; req_addr[2] = 32'h8000_0020;
    req_wdata[2] = 32'hCAFE_F00D; req_wmask[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 0;
    check("l4_waiting", 2, 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("rst_rsp_valid", 2, 32'(rsp_valid[2]), 32'd0);
    check("rst_req_ready", 2, 32'(req_ready[2]), 32'd1);
    @(negedge clk); @(negedge clk); #1 rst = 1;
    xact(2, 0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lt);
    check("abandoned_write", 2, rd, 32'h1111_1111); check("l4_rd_lat", 2, lt, 4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's instruction-fetch and load/store request interface.
- Accepts one read or write request at a time over a valid/ready request channel.
- Performs the access on an internal word-addressed RAM after a fixed, programmable latency.
- Returns read data plus an error flag over a valid/ready response channel. It replaces the zero-latency direct-call memory model so that ifu/lsu handshakes are exercised with real wait states.

Parameters:
- DEPTH, 1024, number of 32-bit words in internal RAM; power of two.
- BASE, 32'h80000000, byte address mapped to word 0.
- LATENCY, 1, cycles from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte enables for writes; bit i enables byte i (bits 8i+7:8i).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- States are IDLE, WAIT and RESP.
- Reset (rst=0, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - RAM contents are not reset.
- req_ready = (state == IDLE), purely from state. A request is accepted on the rising edge where req_valid & req_ready.
- On accept, latch wen, addr, wdata and wmask.
  - If LATENCY == 1, go to RESP.
  - Otherwise go to WAIT with counter = LATENCY-2.
- WAIT: decrement counter each cycle; when counter == 0, go to RESP on the next edge.
- The access is performed on the edge that enters RESP.
  - Write: bytes with mask bit set are updated; rsp_rdata = 0.
  - Read: rsp_rdata = RAM[index].
  - rsp_valid rises in the same cycle the access occurs.
- Net latency: rsp_valid is high exactly LATENCY cycles after the accepting edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that edge go to IDLE and clear rsp_valid. req_ready is high the following cycle.
  - There is no same-cycle response/request overlap, so minimum request spacing is LATENCY+1 cycles.
- Address decode: offset = req_addr - BASE (32-bit wrap); index = offset[31:2].
  - Misaligned access (addr[1:0] != 0): rsp_err = 1, rsp_rdata = 0, no RAM write.
  - Out of range (offset >= DEPTH*4, including addr < BASE via wrap): rsp_err = 1, rsp_rdata = 0, no RAM write.
  - Error responses still take LATENCY cycles and use the normal handshake.
- Write with req_wmask = 0 is legal: no bytes change, rsp_err = 0.
- Requester signals are ignored outside IDLE, so changes to them while waiting have no effect.
- rsp_ready held high while idle has no effect.
- Reset mid-operation: the transaction is abandoned. A write not yet at RESP entry is never committed. A write already committed stays committed.
- The read path is the registered RAM output; no combinational path runs from req_* to rsp_*.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- LATENCY=1:
  - Write addr 0x80000010, data 0xDEADBEEF, mask 4'hF -> rsp_valid one cycle later, rsp_err=0, rsp_rdata=0.
  - Then read 0x80000010 -> rsp_rdata=0xDEADBEEF one cycle after accept.
- Byte mask: after the above, write 0x11223344 with mask 4'b0101 to 0x80000010, then read -> rsp_rdata=0xDE22BE44.
- LATENCY=3 with backpressure:
  - Read accepted at cycle t -> rsp_valid first high at t+3.
  - Hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
  - Raise rsp_ready -> handshake, req_ready=1 the next cycle.
- Errors:
  - Read 0x80000002 -> rsp_err=1, rsp_rdata=0.
  - Write 0x7FFFFFFC -> rsp_err=1.
  - Write 0x80001000 with DEPTH=1024 -> rsp_err=1; a subsequent read of 0x80000000 is unchanged.
- Reset mid-write with LATENCY=4:
  - Write 0xCAFEF00D to 0x80000020, assert rst in the WAIT state, release.
  - Read 0x80000020 -> previous contents returned, not 0xCAFEF00D; rsp_valid was 0 immediately on reset assertion.
